// File: rtl/dac_spi_tx_if.sv
// Word-handshake bundle between an in-fabric code source and the DAC transmitter.
interface dac_spi_tx_if;
  logic [15:0] data_in;
  logic        valid_in;
  logic        signed_in;
  logic        ready_out;

  modport master (output data_in, output valid_in, output signed_in, input ready_out);
  modport slave  (input data_in, input valid_in, input signed_in, output ready_out);
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises 16-bit DAC codes into a CS-framed, MSB-first SPI word followed
// by an optional LDAC load strobe. Signed codes are flipped to offset binary.
module dac_spi_tx #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int LDAC_W   = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  dac_spi_tx_if.slave  bus,
  output logic         sclk_out,
  output logic         sdi_out,
  output logic         cs_n_out,
  output logic         ldac_n_out,
  output logic         done_out
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, LOAD} state_t;

  localparam int DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int TMR_MAX = (CS_SETUP > LDAC_W) ? CS_SETUP : LDAC_W;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic               sclk_q, sclk_d;
  logic               sdi_q, sdi_d;
  logic               cs_n_q, cs_n_d;
  logic               ldac_n_q, ldac_n_d;
  logic               done_q, done_d;
  logic [15:0]        sh_q, sh_d;
  logic [3:0]         bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               accept;
  logic [15:0]        word_c;

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = ldac_n_q;
    done_d   = 1'b0;
    sh_d     = sh_q;
    bit_d    = bit_q;
    div_d    = div_q;
    tmr_d    = tmr_q;
    accept   = bus.valid_in & ready_q;
    word_c   = bus.data_in ^ {bus.signed_in, 15'b0};

    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        cs_n_d   = 1'b1;
        sclk_d   = 1'b0;
        ldac_n_d = 1'b1;
        if (accept) begin
          sh_d    = word_c;
          sdi_d   = word_c[15];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          tmr_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (int'(tmr_q) == CS_SETUP - 1) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      SHIFT: begin
        if (int'(div_q) == CLK_DIV - 1) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd15) begin
              cs_n_d = 1'b1;
              sdi_d  = 1'b0;
              tmr_d  = '0;
              if (LDAC_W == 0) begin
                ready_d = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                ldac_n_d = 1'b0;
                state_d  = LOAD;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[14:0], 1'b0};
              sdi_d = sh_q[14];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      LOAD: begin
        if (int'(tmr_q) == LDAC_W - 1) begin
          ldac_n_d = 1'b1;
          ready_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered state and pins; reset aborts any frame without a load strobe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      done_q   <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
      done_q   <= done_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      tmr_q    <= tmr_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign sclk_out      = sclk_q;
  assign sdi_out       = sdi_q;
  assign cs_n_out      = cs_n_q;
  assign ldac_n_out    = ldac_n_q;
  assign done_out      = done_q;

endmodule
